// File: rtl/pool_stream_flex_if.sv
// Pixel stream interface for pool_stream_flex: input beats in, pooled pixels out.
// The master drives pixels and output backpressure; the slave is the pooling unit.
interface pool_stream_flex_if #(
    parameter int CHANNELS = 2,
    parameter int ACT_BITS = 3
) ();
    logic                         in_valid;
    logic                         in_ready;
    logic [CHANNELS*ACT_BITS-1:0] in_data;
    logic                         out_valid;
    logic                         out_ready;
    logic [CHANNELS*ACT_BITS-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/pool_stream_flex.sv
// Streaming non-overlapping 2^k x 2^k max/average pooling over row-major pixels,
// keeping only one row of partial window results in a column buffer.
module pool_stream_flex #(
    parameter int CHANNELS     = 2,
    parameter int ACT_BITS     = 3,
    parameter int MAX_WIDTH    = 28,
    parameter int MAX_HEIGHT   = 28,
    parameter int KER_LOG2_MAX = 2
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start,
    input  logic                                  cfg_max_n_avg,
    input  logic [$clog2(KER_LOG2_MAX+1)-1:0]     cfg_ker_log2,
    input  logic [$clog2(MAX_WIDTH+1)-1:0]        cfg_width,
    input  logic [$clog2(MAX_HEIGHT+1)-1:0]       cfg_height,
    pool_stream_flex_if.slave                     strm,
    output logic                                  busy,
    output logic                                  done
);
    localparam int KW    = $clog2(KER_LOG2_MAX + 1);
    localparam int WW    = $clog2(MAX_WIDTH + 1);
    localparam int HW    = $clog2(MAX_HEIGHT + 1);
    localparam int ACC_W = ACT_BITS + 2 * KER_LOG2_MAX;
    localparam int DEPTH = MAX_WIDTH / 2;
    localparam int IW    = $clog2(DEPTH);
    localparam int DW    = CHANNELS * ACT_BITS;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_e;

    state_e                 state_q, state_d;
    logic                   max_q, max_d;
    logic [KW-1:0]          k_q, k_d;
    logic [WW-1:0]          width_q, width_d, col_q, col_d, kmask_c;
    logic [HW-1:0]          height_q, height_d, row_q, row_d, kmask_r;
    logic [ACC_W-1:0]       acc_q [CHANNELS];
    logic [ACC_W-1:0]       acc_d [CHANNELS];
    logic                   out_valid_q, out_valid_d;
    logic [DW-1:0]          out_data_q, out_data_d;

    logic [ACC_W-1:0]       col_buf_q [CHANNELS][DEPTH];
    logic                   buf_we;
    logic [IW-1:0]          buf_idx;
    logic [ACC_W-1:0]       buf_wdata [CHANNELS];

    logic in_ready_w, fire, grp_first, grp_last, band_first, band_last, window_done;

    function automatic logic [ACC_W-1:0] merge(input logic is_max,
                                               input logic [ACC_W-1:0] a,
                                               input logic [ACC_W-1:0] b);
        if (is_max) return (a > b) ? a : b;
        return a + b;
    endfunction

    assign in_ready_w    = (state_q == RUN) && (!out_valid_q || strm.out_ready);
    assign fire          = strm.in_valid && in_ready_w;
    assign strm.in_ready = in_ready_w;
    assign strm.out_valid = out_valid_q;
    assign strm.out_data  = out_data_q;
    assign busy          = (state_q != IDLE);
    assign done          = (state_q == FLUSH) && (!out_valid_q || strm.out_ready);

    // Window geometry: a group/band only counts if its last column/row lies inside the frame.
    assign kmask_c     = WW'((1 << k_q) - 1);
    assign kmask_r     = HW'((1 << k_q) - 1);
    assign grp_first   = (col_q & kmask_c) == '0;
    assign grp_last    = (col_q & kmask_c) == kmask_c;
    assign band_first  = (row_q & kmask_r) == '0;
    assign band_last   = (row_q & kmask_r) == kmask_r;
    assign window_done = grp_last && ((col_q | kmask_c) < width_q) && ((row_q | kmask_r) < height_q);
    assign buf_idx     = IW'(col_q >> k_q);

    always_comb begin
        logic [ACC_W-1:0] px;
        logic [ACC_W-1:0] acc_new;
        logic [ACC_W-1:0] band_val;
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        state_d     = state_q;
        max_d       = max_q;
        k_d         = k_q;
        width_d     = width_q;
        height_d    = height_q;
        col_d       = col_q;
        row_d       = row_q;
        acc_d       = acc_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q && !strm.out_ready;
        buf_we      = 1'b0;
        px          = '0;
        acc_new     = '0;
        band_val    = '0;
        for (int c = 0; c < CHANNELS; c++) buf_wdata[c] = '0;

        case (state_q)
            IDLE: if (start) begin
                max_d    = cfg_max_n_avg;
                k_d      = (cfg_ker_log2 == '0) ? KW'(1) :
                           (cfg_ker_log2 > KW'(KER_LOG2_MAX)) ? KW'(KER_LOG2_MAX) : cfg_ker_log2;
                width_d  = cfg_width;
                height_d = cfg_height;
                col_d    = '0;
                row_d    = '0;
                state_d  = (cfg_width == '0 || cfg_height == '0) ? FLUSH : RUN;
            end
            RUN: if (fire) begin
                for (int c = 0; c < CHANNELS; c++) begin
                    px       = ACC_W'(strm.in_data[c*ACT_BITS +: ACT_BITS]);
                    acc_new  = grp_first ? px : merge(max_q, acc_q[c], px);
                    acc_d[c] = acc_new;
                    band_val = band_first ? acc_new : merge(max_q, col_buf_q[c][buf_idx], acc_new);
                    buf_wdata[c] = band_val;
                    if (window_done && band_last)
                        out_data_d[c*ACT_BITS +: ACT_BITS] =
                            ACT_BITS'(max_q ? band_val : (band_val >> {k_q, 1'b0}));
                end
                if (window_done) begin
                    if (band_last) out_valid_d = 1'b1;
                    else           buf_we      = 1'b1;
                end
                if (col_q == width_q - WW'(1)) begin
                    col_d = '0;
                    row_d = row_q + HW'(1);
                    if (row_q == height_q - HW'(1)) state_d = FLUSH;
                end else begin
                    col_d = col_q + WW'(1);
                end
            end
            FLUSH: if (!out_valid_q || strm.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            max_q       <= 1'b0;
            k_q         <= '0;
            width_q     <= '0;
            height_q    <= '0;
            col_q       <= '0;
            row_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            for (int c = 0; c < CHANNELS; c++) acc_q[c] <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            state_q     <= state_d;
            max_q       <= max_d;
            k_q         <= k_d;
            width_q     <= width_d;
            height_q    <= height_d;
            col_q       <= col_d;
            row_q       <= row_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            acc_q       <= acc_d;
        end
    end

    // NOTE: the column buffer has no reset; the first row of every band overwrites an entry before it is read.
    always_ff @(posedge clk) begin
        if (buf_we)
            for (int c = 0; c < CHANNELS; c++) col_buf_q[c][buf_idx] <= buf_wdata[c];
    end
endmodule
